// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock with start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [WIDTH-1:0] ra, rb, acc, acc_next;
  logic             c, last, msb_ovf;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  // digit adder; the new digit enters the sum shift register from the top
  always_comb begin
    dsum = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
    acc_next = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last = cnt == CW'(STEPS - 1);
    msb_ovf = (ra[DIGIT-1] == rb[DIGIT-1]) && (dsum[DIGIT-1] != ra[DIGIT-1]);
  end
  // handshake FSM with registered results; outputs only move on completion or reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          ra    <= a;
          rb    <= b;
          c     <= cin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
      end else begin
        ra  <= ra >> DIGIT;
        rb  <= rb >> DIGIT;
        c   <= dsum[DIGIT];
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (last) begin
          sum   <= acc_next;
          carry <= dsum[DIGIT];
          ovf   <= msb_ovf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: three adder configurations checked against a transaction-level model
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n, start, cin;
  logic [7:0] a, b;
  logic [2:0] bz, dn, cy, ov;
  logic [7:0] sm [3];
  logic [1:0] sum2;
  int         errors = 0, checks = 0;
  bit         chk_en = 1'b0;
  int         lat [3];
  int         bcnt, dcnt;
  // expected state per instance: 0 = W8/D1, 1 = W8/D4, 2 = W2/D1
  bit         m_busy [3];
  int         m_left [3];
  int         p_sum [3], p_cy [3], p_ov [3];
  logic       e_busy [3], e_done [3];
  int         e_sum [3], e_cy [3], e_ov [3];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .cin(cin), .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .carry(cy[0]), .ovf(ov[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .cin(cin), .busy(bz[1]), .done(dn[1]), .sum(sm[1]), .carry(cy[1]), .ovf(ov[1]));
  serial_adder #(.WIDTH(2), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .a(a[1:0]),
    .b(b[1:0]), .cin(cin), .busy(bz[2]), .done(dn[2]), .sum(sum2), .carry(cy[2]), .ovf(ov[2]));
  assign sm[2] = {6'b0, sum2};

  function automatic int wof(input int k);
    return k == 2 ? 2 : 8;
  endfunction

  function automatic int stof(input int k);
    return k == 0 ? 8 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: result is plain integer addition; only the STEPS-edge latency is modelled
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_left[k] = 0;
        e_done[k] = 0; e_sum[k] = 0; e_cy[k] = 0; e_ov[k] = 0;
      end else if (m_busy[k]) begin
        m_left[k]--;
        e_done[k] = m_left[k] == 0;
        if (m_left[k] == 0) begin
          m_busy[k] = 0;
          e_sum[k] = p_sum[k]; e_cy[k] = p_cy[k]; e_ov[k] = p_ov[k];
        end
      end else begin
        e_done[k] = 0;
        if (start) begin
          int w, mask, am, bm, full;
          w = wof(k);
          mask = (1 << w) - 1;
          am = int'(a) & mask;
          bm = int'(b) & mask;
          full = am + bm + int'(cin);
          p_sum[k] = full & mask;
          p_cy[k] = (full >> w) & 1;
          p_ov[k] = int'((((am >> (w-1)) & 1) == ((bm >> (w-1)) & 1)) &&
                         (((p_sum[k] >> (w-1)) & 1) != ((am >> (w-1)) & 1)));
          m_busy[k] = 1;
          m_left[k] = stof(k);
        end
      end
      e_busy[k] = m_busy[k];
    end
  end

  // per-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(e_busy[k]));
        chk($sformatf("done%0d", k), 32'(dn[k]), 32'(e_done[k]));
        chk($sformatf("sum%0d", k), 32'(sm[k]), e_sum[k]);
        chk($sformatf("carry%0d", k), 32'(cy[k]), e_cy[k]);
        chk($sformatf("ovf%0d", k), 32'(ov[k]), e_ov[k]);
      end
    end
  end

  // issue one start (immediately when now=1), then return in the cycle u0 signals done
  task automatic go(input logic [7:0] aa, input logic [7:0] bb, input logic c, input bit now = 0);
    if (!now) @(negedge clk);
    a = aa; b = bb; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = '{0, 0, 0};
    bcnt = 0;
    for (int n = 1; n < 40; n++) begin
      if (bz[0]) bcnt++;
      for (int k = 0; k < 3; k++) if (dn[k] && lat[k] == 0) lat[k] = n;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(negedge clk);
    end
    chk("done_seen", 32'(lat[0] != 0 && lat[1] != 0 && lat[2] != 0), 32'd1);
  endtask

  task automatic wait_done0;
    for (int n = 0; n < 40 && !dn[0]; n++) @(negedge clk);
    chk("done0_seen", 32'(dn[0]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bz), 32'd0);
    chk("rst_done", 32'(dn), 32'd0);
    chk("rst_sum", 32'(sm[0]), 32'd0);
    chk("rst_cy_ov", 32'({cy, ov}), 32'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    go(8'h00, 8'h00, 1'b0);
    chk("lat_w8d1", lat[0], 9);
    chk("busy_cycles", bcnt, 8);
    chk("lat_w8d4", lat[1], 3);
    chk("zero_sum", 32'({cy[0], ov[0], sm[0]}), 32'h000);
    go(8'hFF, 8'h01, 1'b0);
    chk("ff01", 32'({cy[0], ov[0], sm[0]}), 32'h200);
    go(8'h7F, 8'h01, 1'b0);
    chk("7f01", 32'({cy[0], ov[0], sm[0]}), 32'h180);
    go(8'h80, 8'h80, 1'b0);
    chk("8080", 32'({cy[0], ov[0], sm[0]}), 32'h300);
    go(8'hA5, 8'h5A, 1'b1);
    chk("a55a_d4", 32'({cy[1], sm[1]}), 32'h100);
    chk("a55a_lat", lat[1], 3);
    chk("a55a_d1", 32'({cy[0], sm[0]}), 32'h100);
    // start pulse while busy must not disturb the running operation
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done0();
    chk("ignore_busy", 32'({cy[0], sm[0]}), 32'h046);
    // back-to-back: start asserted in the done cycle
    go(8'h10, 8'h20, 1'b1, 1);
    chk("b2b_lat", lat[0], 9);
    chk("b2b_sum", 32'({cy[0], sm[0]}), 32'h031);
    // reset at the fourth RUN edge aborts the operation
    @(negedge clk);
    a = 8'h55; b = 8'h33; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(bz[0]), 32'd0);
    chk("abort_out", 32'({cy[0], ov[0], sm[0]}), 32'd0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[0]) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int c = 0; c < 2; c++) begin
          go(8'(i), 8'(j), 1'(c));
          chk($sformatf("w2_%0d_%0d_%0d", i, j, c), 32'({cy[2], sum2}), i + j + c);
        end
    repeat (40) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      go(ra, rb, rc, 1'($urandom));
      chk("rand_sum", 32'({cy[0], sm[0]}), 32'(ra) + 32'(rb) + 32'(rc));
      chk("rand_d4", 32'({cy[1], sm[1]}), 32'(ra) + 32'(rb) + 32'(rc));
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
